// File: rtl/seq_align_shifter_pkg.sv
// ---------------------------------------------------------------------------
// seq_align_shifter_pkg
// Shared definitions for the sequential FP align/normalise shifter.
//   - state_t    : FSM state encoding (S_IDLE / S_SHIFT / S_DONE)
//   - MODE_ALIGN : right shift with sticky collection
//   - MODE_NORM  : left shift until the leading one reaches the MSB
//   - DEF_W/DEF_SW : defaults for the single-precision adder datapath
// ---------------------------------------------------------------------------
package seq_align_shifter_pkg;

    localparam int DEF_W  = 26;
    localparam int DEF_SW = 5;

    localparam logic MODE_ALIGN = 1'b0;
    localparam logic MODE_NORM  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shift_dp.sv
// ---------------------------------------------------------------------------
// seq_shift_dp
// Shift register datapath for seq_align_shifter.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : load q from load_data, clear sticky
//   shift      : shift q one position (direction chosen by dir)
//   dir        : MODE_ALIGN = right shift, MODE_NORM = left shift
//   load_data  : operand to load
//   q          : shift register contents
//   sticky     : OR of every bit shifted out on the right (right shifts only)
// load has priority over shift.
// ---------------------------------------------------------------------------
module seq_shift_dp
    import seq_align_shifter_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic         dir,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] q,
    output logic         sticky
);

    logic [W-1:0] q_next;
    logic         sticky_next;

    always_comb begin
        q_next      = q;
        sticky_next = sticky;
        if (load) begin
            q_next      = load_data;
            sticky_next = 1'b0;
        end else if (shift) begin
            if (dir == MODE_ALIGN) begin
                q_next      = {1'b0, q[W-1:1]};
                sticky_next = sticky | q[0];
            end else begin
                // Left shifts never discard a one that matters to sticky.
                q_next = {q[W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q      <= '0;
            sticky <= 1'b0;
        end else begin
            q      <= q_next;
            sticky <= sticky_next;
        end
    end

endmodule

// File: rtl/seq_align_shifter.sv
// ---------------------------------------------------------------------------
// seq_align_shifter
// Sequential mantissa shifter, one position per clock.
//   ALIGN (mode=0): right shift by shamt_in, collecting a sticky bit.
//   NORM  (mode=1): left shift until the MSB is one or the budget is spent.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request, sampled only in IDLE
//   mode         : 0 = ALIGN, 1 = NORM, latched on accepted start
//   data_in      : operand, latched on accepted start
//   shamt_in     : shift budget, latched on accepted start
//   busy         : high while shifting
//   done         : one-cycle pulse, result valid
//   data_out     : shift register contents (valid with done, held until
//                  the next accepted start)
//   sticky       : OR of all bits shifted out (ALIGN only)
//   shift_count  : number of shifts performed
// Handshake: start is accepted on a clock edge only while IDLE; busy marks
// the SHIFT state, during which start is ignored; done pulses for exactly
// one cycle in DONE, after which the block returns to IDLE unconditionally.
// ---------------------------------------------------------------------------
module seq_align_shifter
    import seq_align_shifter_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int SW = DEF_SW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [W-1:0]  data_in,
    input  logic [SW-1:0] shamt_in,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  data_out,
    output logic          sticky,
    output logic [SW-1:0] shift_count
);

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] remaining;
    logic          mode_q;
    logic          load;
    logic          shift;
    logic [W-1:0]  q;

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    // Nothing to do: zero budget, or already normalised.
                    if (shamt_in == '0 || (mode == MODE_NORM && data_in[W-1]))
                        state_next = S_DONE;
                    else
                        state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift = 1'b1;
                // q[W-2] becomes the MSB after this shift.
                if (remaining == SW'(1) || (mode_q == MODE_NORM && q[W-2]))
                    state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Budget, count and mode registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining   <= '0;
            shift_count <= '0;
            mode_q      <= MODE_ALIGN;
        end else if (load) begin
            remaining   <= shamt_in;
            shift_count <= '0;
            mode_q      <= mode;
        end else if (shift) begin
            remaining   <= remaining - SW'(1);
            shift_count <= shift_count + SW'(1);
        end
    end

    seq_shift_dp #(
        .W (W)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .dir       (mode_q),
        .load_data (data_in),
        .q         (q),
        .sticky    (sticky)
    );

    assign data_out = q;
    assign busy     = (state == S_SHIFT);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_seq_align_shifter.sv
module tb_seq_align_shifter;

    localparam int W  = 8;
    localparam int SW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          mode;
    logic [W-1:0]  data_in;
    logic [SW-1:0] shamt_in;
    logic          busy;
    logic          done;
    logic [W-1:0]  data_out;
    logic          sticky;
    logic [SW-1:0] shift_count;

    int n_tests = 0;
    int n_fail  = 0;

    seq_align_shifter #(
        .W  (W),
        .SW (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .data_in     (data_in),
        .shamt_in    (shamt_in),
        .busy        (busy),
        .done        (done),
        .data_out    (data_out),
        .sticky      (sticky),
        .shift_count (shift_count)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: result of the whole operation from the arithmetic rules.
    //   ALIGN: data >> shamt, sticky = OR of the discarded low bits.
    //   NORM : shift left by min(leading zeros, shamt) (full budget if zero).
    task automatic model(input logic m, input logic [W-1:0] d, input logic [SW-1:0] s,
                         output logic [W-1:0] res, output logic stk, output int n);
        int lz;
        if (m == 1'b0) begin
            n = int'(s);
            if (n >= W) begin
                res = '0;
                stk = |d;
            end else begin
                res = d >> n;
                stk = |(int'(d) & ((1 << n) - 1));
            end
        end else begin
            lz = 0;
            while (lz < W && d[W-1-lz] == 1'b0) lz++;
            n   = (lz < int'(s)) ? lz : int'(s);
            res = (n >= W) ? '0 : (d << n);
            stk = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present an operation and let the start edge happen.
    task automatic launch(input logic m, input logic [W-1:0] d, input logic [SW-1:0] s);
        mode     = m;
        data_in  = d;
        shamt_in = s;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Follow an accepted operation cycle by cycle. junk[c] drives start in
    // cycle c (with random operands) to prove it is ignored; with hold set,
    // start stays high carrying the next operation's operands.
    task automatic track(input logic m, input logic [W-1:0] d, input logic [SW-1:0] s,
                         input logic [15:0] junk, input logic hold,
                         input logic nm, input logic [W-1:0] nd, input logic [SW-1:0] ns);
        logic [W-1:0] er;
        logic         es;
        int           n;
        model(m, d, s, er, es, n);
        for (int c = 0; c <= n; c++) begin
            if (hold) begin
                start    = 1'b1;
                mode     = nm;
                data_in  = nd;
                shamt_in = ns;
            end else begin
                start = junk[c];
                if (junk[c]) begin
                    mode     = 1'($urandom);
                    data_in  = W'($urandom);
                    shamt_in = SW'($urandom);
                end
            end
            @(negedge clk);
            if (c < n) begin
                check("busy_shift", 32'(busy), 32'd1);
                check("done_early", 32'(done), 32'd0);
            end else begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_done", 32'(busy), 32'd0);
                check("data_out", 32'(data_out), 32'(er));
                check("sticky", 32'(sticky), 32'(es));
                check("shift_count", 32'(shift_count), 32'(n));
            end
            @(posedge clk);
            #1;
        end
        start = hold;
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_hold", 32'(data_out), 32'(er));
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        mode     = 1'b0;
        data_in  = '0;
        shamt_in = '0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_sticky", 32'(sticky), 32'd0);
        check("rst_count", 32'(shift_count), 32'd0);
        do_reset();

        // 1: ALIGN right shift with sticky
        launch(1'b0, 8'b1011_0110, 4'd3);
        track(1'b0, 8'b1011_0110, 4'd3, 16'h0, 1'b0, 1'b0, 8'h0, 4'd0);
        check("t1_const", 32'(data_out), 32'h16);

        // 2: zero budget, then budget beyond the width
        launch(1'b0, 8'hA5, 4'd0);
        track(1'b0, 8'hA5, 4'd0, 16'h0, 1'b0, 1'b0, 8'h0, 4'd0);
        launch(1'b0, 8'h01, 4'd12);
        track(1'b0, 8'h01, 4'd12, 16'h0, 1'b0, 1'b0, 8'h0, 4'd0);

        // 3: NORM early stop, then already normalised
        launch(1'b1, 8'b0001_0100, 4'd7);
        track(1'b1, 8'b0001_0100, 4'd7, 16'h0, 1'b0, 1'b0, 8'h0, 4'd0);
        check("t3_const", 32'(data_out), 32'hA0);
        launch(1'b1, 8'h80, 4'd7);
        track(1'b1, 8'h80, 4'd7, 16'h0, 1'b0, 1'b0, 8'h0, 4'd0);

        // 4: NORM of zero spends the whole budget
        launch(1'b1, 8'h00, 4'd5);
        track(1'b1, 8'h00, 4'd5, 16'h0, 1'b0, 1'b0, 8'h0, 4'd0);

        // 5: start pulses while busy and in DONE, then start held high
        launch(1'b0, 8'hE7, 4'd4);
        track(1'b0, 8'hE7, 4'd4, 16'h0013, 1'b0, 1'b0, 8'h0, 4'd0);
        launch(1'b0, 8'h5A, 4'd2);
        track(1'b0, 8'h5A, 4'd2, 16'hFFFF, 1'b1, 1'b1, 8'h03, 4'd7);
        @(posedge clk);
        #1;
        start = 1'b0;
        track(1'b1, 8'h03, 4'd7, 16'h0, 1'b0, 1'b0, 8'h0, 4'd0);

        // 6: asynchronous reset mid-shift
        launch(1'b0, 8'hC3, 4'd6);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_data", 32'(data_out), 32'd0);
        check("arst_sticky", 32'(sticky), 32'd0);
        check("arst_count", 32'(shift_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("arst_no_done", 32'(done), 32'd0);
        end
        launch(1'b0, 8'b1011_0110, 4'd3);
        track(1'b0, 8'b1011_0110, 4'd3, 16'h0, 1'b0, 1'b0, 8'h0, 4'd0);

        // random operations with random start noise
        for (int k = 0; k < 60; k++) begin
            logic          m;
            logic [W-1:0]  d;
            logic [SW-1:0] s;
            m = 1'($urandom_range(0, 1));
            d = W'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) d = d >> $urandom_range(3, 8);
            s = SW'($urandom_range(0, 15));
            launch(m, d, s);
            track(m, d, s, 16'($urandom), 1'b0, 1'b0, 8'h0, 4'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
